// File: rtl/arm_dp_execute_if.sv
// Operand/result handshake bundle for the ARM data-processing execute stage.
// master = upstream/downstream side, slave = the execute stage itself.
interface arm_dp_execute_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] rn_data;
  logic [31:0] operand2;
  logic        potential_cout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_rd;
  logic        out_wr_en;
  logic [31:0] cpsr;

  modport master (
    output in_valid, inst, rn_data, operand2, potential_cout, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_wr_en, cpsr
  );

  modport slave (
    input  in_valid, inst, rn_data, operand2, potential_cout, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_wr_en, cpsr
  );
endinterface

// File: rtl/arm_dp_execute.sv
// ARM data-processing execute stage: 16-opcode ALU, NZCV flags, one-deep output register.
// Define ARM_EXEC_COND_EN to evaluate inst[31:28] condition codes; otherwise every instruction runs as AL.
module arm_dp_execute (
  input logic            clk,
  input logic            rst_b,
  arm_dp_execute_if.slave bus
);
  localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE, OP_MVN = 4'hF;
  localparam logic [27:0] CPSR_LOW = 28'h0000010;

  logic [3:0]  opcode;
  logic        s_bit;
  logic        accept;
  logic        cond_pass;
  logic        is_arith;
  logic        is_test;
  logic        carry_in;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [32:0] sum;
  logic        add_ovf;
  logic [31:0] logic_result;
  logic [31:0] alu_result;
  logic [3:0]  next_nzcv;

  logic        valid_q;
  logic [31:0] result_q;
  logic [3:0]  rd_q;
  logic        wr_en_q;
  logic [3:0]  nzcv;

  assign opcode = bus.inst[24:21];
  assign s_bit  = bus.inst[20];
  assign is_test = (opcode[3:2] == 2'b10);

  assign bus.in_ready = !valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Subtractions feed the inverted operand to a shared 33-bit adder so carry-out is NOT borrow.
  always_comb begin
    add_a        = bus.rn_data;
    add_b        = bus.operand2;
    carry_in     = 1'b0;
    is_arith     = 1'b1;
    logic_result = 32'h0;
    case (opcode)
      OP_SUB, OP_CMP: begin add_b = ~bus.operand2; carry_in = 1'b1; end
      OP_RSB:         begin add_a = bus.operand2; add_b = ~bus.rn_data; carry_in = 1'b1; end
      OP_ADD, OP_CMN: carry_in = 1'b0;
      OP_ADC:         carry_in = nzcv[1];
      OP_SBC:         begin add_b = ~bus.operand2; carry_in = nzcv[1]; end
      OP_RSC:         begin add_a = bus.operand2; add_b = ~bus.rn_data; carry_in = nzcv[1]; end
      OP_AND, OP_TST: begin is_arith = 1'b0; logic_result = bus.rn_data & bus.operand2; end
      OP_EOR, OP_TEQ: begin is_arith = 1'b0; logic_result = bus.rn_data ^ bus.operand2; end
      OP_ORR:         begin is_arith = 1'b0; logic_result = bus.rn_data | bus.operand2; end
      OP_MOV:         begin is_arith = 1'b0; logic_result = bus.operand2; end
      OP_BIC:         begin is_arith = 1'b0; logic_result = bus.rn_data & ~bus.operand2; end
      OP_MVN:         begin is_arith = 1'b0; logic_result = ~bus.operand2; end
      default:        is_arith = 1'b1;
    endcase
  end

  assign sum        = {1'b0, add_a} + {1'b0, add_b} + {32'h0, carry_in};
  assign add_ovf    = (add_a[31] == add_b[31]) && (sum[31] != add_a[31]);
  assign alu_result = is_arith ? sum[31:0] : logic_result;

  // Logical ops take C from the shifter and keep the old V.
  assign next_nzcv = {alu_result[31],
                      (alu_result == 32'h0),
                      is_arith ? sum[32] : bus.potential_cout,
                      is_arith ? add_ovf : nzcv[0]};

`ifdef ARM_EXEC_COND_EN
  always_comb begin
    cond_pass = 1'b0;
    case (bus.inst[31:28])
      4'h0: cond_pass = nzcv[2];
      4'h1: cond_pass = !nzcv[2];
      4'h2: cond_pass = nzcv[1];
      4'h3: cond_pass = !nzcv[1];
      4'h4: cond_pass = nzcv[3];
      4'h5: cond_pass = !nzcv[3];
      4'h6: cond_pass = nzcv[0];
      4'h7: cond_pass = !nzcv[0];
      4'h8: cond_pass = nzcv[1] && !nzcv[2];
      4'h9: cond_pass = !nzcv[1] || nzcv[2];
      4'hA: cond_pass = (nzcv[3] == nzcv[0]);
      4'hB: cond_pass = (nzcv[3] != nzcv[0]);
      4'hC: cond_pass = !nzcv[2] && (nzcv[3] == nzcv[0]);
      4'hD: cond_pass = nzcv[2] || (nzcv[3] != nzcv[0]);
      4'hE: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end
`else
  assign cond_pass = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      valid_q  <= 1'b0;
      result_q <= 32'h0;
      rd_q     <= 4'h0;
      wr_en_q  <= 1'b0;
      nzcv     <= 4'h0;
    end else if (accept) begin
      valid_q  <= 1'b1;
      result_q <= alu_result;
      rd_q     <= bus.inst[15:12];
      wr_en_q  <= cond_pass && !is_test;
      if (s_bit && cond_pass)
        nzcv <= next_nzcv;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_valid  = valid_q;
  assign bus.out_result = result_q;
  assign bus.out_rd     = rd_q;
  assign bus.out_wr_en  = wr_en_q;
  assign bus.cpsr       = {nzcv, CPSR_LOW};
endmodule

// File: doc/arm_dp_execute.md
ARM_DP_EXECUTE -- requirements
Module: arm_dp_execute

Interface
REQ-001 SHALL have clk, input, 1, single clock; all state on rising edge.
REQ-002 SHALL have rst_b, input, 1, asynchronous active-low reset.
REQ-003 SHALL have in_valid, input, 1, upstream operands valid.
REQ-004 SHALL have in_ready, output, 1, stage can accept this cycle.
REQ-005 SHALL have inst, input, 32, data-processing instruction: cond [31:28], opcode [24:21], S [20], Rd [15:12].
REQ-006 SHALL have rn_data, input, 32, first operand.
REQ-007 SHALL have operand2, input, 32, shifted/rotated second operand from the shifter stage.
REQ-008 SHALL have potential_cout, input, 1, shifter carry-out.
REQ-009 SHALL have out_valid, output, 1, registered result valid.
REQ-010 SHALL have out_ready, input, 1, downstream accepts result.
REQ-011 SHALL have out_result, output, 32, registered ALU result.
REQ-012 SHALL have out_rd, output, 4, destination register.
REQ-013 SHALL have out_wr_en, output, 1, write Rd.
REQ-014 SHALL have cpsr, output, 32, current status word; feeds the shifter's cpsr input; N/Z/C/V in [31:28].

Function
REQ-015 SHALL compute in_ready = !out_valid || out_ready, combinationally.
REQ-016 SHALL accept when in_valid && in_ready; out_valid, out_result, out_rd and out_wr_en load on the next edge (latency 1).
REQ-017 SHALL clear out_valid on out_valid && out_ready with no accept; simultaneous drain and accept reloads with out_valid held 1.
REQ-018 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-019 SHALL implement the 16 opcodes: AND, EOR, SUB, RSB, ADD, ADC, SBC, RSC, TST, TEQ, CMP, CMN, ORR, MOV, BIC, MVN.
REQ-020 SHALL perform arithmetic in 33 bits; ADC/SBC/RSC use the current cpsr[29] as carry-in; subtraction carry = NOT borrow.
REQ-021 SHALL set out_wr_en=0 for TST/TEQ/CMP/CMN and 1 for other passing instructions.
REQ-022 SHALL update flags on accept only when S=1 and the condition passes.
REQ-023 Flag rules: N=result[31] and Z=(result==0) always; arithmetic ops take C from the adder carry and V from signed overflow; logical ops take C=potential_cout and leave V unchanged.
REQ-024 SHALL make a flag update visible on cpsr in the cycle after accept, so a back-to-back instruction sees it.
REQ-025 SHALL hold cpsr[27:0] constant at 28'h0000010.
REQ-026 Rd=15 SHALL receive no special treatment.

Reset
REQ-027 SHALL, on rst_b low, immediately force out_valid=0, out_result=0, out_rd=0, out_wr_en=0 and cpsr=32'h0000_0010, independent of clk.
REQ-028 SHALL discard any in-flight result on mid-operation reset; in_ready=1 in the first cycle after release.

Configuration
REQ-029 Macro ARM_EXEC_COND_EN defined: SHALL evaluate all 15 ARM conditions (EQ..AL; 4'b1111 treated as never) against cpsr before accept.
REQ-030 A failing condition SHALL still produce out_valid=1 with out_wr_en=0 and no flag update.
REQ-031 Macro ARM_EXEC_COND_EN undefined: SHALL ignore inst[31:28] and execute every instruction as AL.

Verification
REQ-032 ADDS, rn=32'h7FFFFFFF, op2=1 -> out_result=32'h80000000, cpsr[31:28]=4'b1001 next cycle.
REQ-033 SUBS, rn=5, op2=5 -> out_result=0, N=0 Z=1 C=1 V=0; CMP with the same operands -> identical flags, out_wr_en=0.
REQ-034 MOVS, op2=0, potential_cout=1, prior V=1 -> Z=1, C=1, V stays 1, out_wr_en=1.
REQ-035 out_ready=0 for 3 cycles with out_valid=1 and in_valid=1 -> in_ready=0 and outputs unchanged; out_ready=1 -> new result on next edge, out_valid stays 1.
REQ-036 ARM_EXEC_COND_EN defined, Z=0, ADDEQS -> out_valid=1, out_wr_en=0, cpsr unchanged; same stimulus with macro undefined -> instruction executes.
REQ-037 rst_b low mid-cycle while out_valid=1 -> out_valid=0 and cpsr=32'h0000_0010 before the next edge.
